// File: rtl/fetch.sv
// Instruction fetch stage: PC sequencing, memory request issue, in-order
// response buffering, redirect/flush handling and misaligned-target faults.
// Ports: clock, reset (sync, active-high); stall, flush, redirectValid,
// redirectTarget from the back end; instrReq*/instrResp* to instruction
// memory; outValid/outInstruction/outProgramCounter/outProgramCounterPlus4/
// outFetchFault payload to decode.
module fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        instrReqValid,
  input  logic        instrReqReady,
  output logic [31:0] instrReqAddress,
  input  logic        instrRespValid,
  input  logic [31:0] instrRespData,
  output logic        outValid,
  output logic [31:0] outInstruction,
  output logic [31:0] outProgramCounter,
  output logic [31:0] outProgramCounterPlus4,
  output logic        outFetchFault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    S_FETCH,
    S_HALT
  } state_t;

  state_t state;
  state_t state_n;

  logic [31:0]   pc;
  logic [31:0]   pc_n;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_n;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] drop_n;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] buf_count_n;

  logic [PW-1:0] buf_head;
  logic [PW-1:0] buf_tail;
  logic [PW-1:0] pcq_head;
  logic [PW-1:0] pcq_tail;

  logic [31:0] buf_instr [DEPTH];
  logic [31:0] buf_pc    [DEPTH];
  logic [31:0] pcq       [DEPTH];

  logic        out_valid_n;
  logic        fault_n;
  logic [31:0] instr_n;
  logic [31:0] opc_n;

  logic        accept;
  logic        dropping;
  logic        keep;
  logic        bypass;
  logic        buf_push;
  logic        buf_pop;
  logic [31:0] resp_pc;

  // The output register is not counted: buffer plus in-flight requests
  // are bounded so every response has a slot even under stall.
  assign instrReqValid = (state == S_FETCH) && !redirectValid &&
                         ((outstanding + buf_count) < CW'(DEPTH));
  assign instrReqAddress = pc;

  assign accept   = instrReqValid && instrReqReady;
  assign dropping = instrRespValid && (drop_count != '0);
  assign keep     = instrRespValid && (drop_count == '0);
  assign resp_pc  = pcq[pcq_head];

  assign bypass = keep && !redirectValid && !flush &&
                  (buf_count == '0) && (!outValid || !stall);

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    outstanding_n = outstanding + CW'(accept) - CW'(instrRespValid);
    drop_n        = drop_count;
    buf_count_n   = buf_count;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    out_valid_n   = outValid;
    fault_n       = outFetchFault;
    instr_n       = outInstruction;
    opc_n         = outProgramCounter;

    if (accept) begin
      pc_n = pc + 32'd4;
    end

    if (redirectValid) begin
      pc_n        = redirectTarget;
      drop_n      = outstanding - CW'(instrRespValid);
      buf_count_n = '0;
      out_valid_n = 1'b0;
      fault_n     = 1'b0;
      state_n     = S_FETCH;
      // Misaligned target: emit one NOP-shaped fault payload and park.
      if (redirectTarget[1:0] != 2'b00) begin
        state_n     = S_HALT;
        out_valid_n = 1'b1;
        fault_n     = 1'b1;
        instr_n     = NOP;
        opc_n       = redirectTarget;
      end
    end else begin
      if (dropping) begin
        drop_n = drop_count - 1'b1;
      end

      if (flush) begin
        out_valid_n = 1'b0;
        fault_n     = 1'b0;
      end else if (!stall && (buf_count != '0)) begin
        out_valid_n = 1'b1;
        fault_n     = 1'b0;
        instr_n     = buf_instr[buf_head];
        opc_n       = buf_pc[buf_head];
        buf_pop     = 1'b1;
      end else if (bypass) begin
        out_valid_n = 1'b1;
        fault_n     = 1'b0;
        instr_n     = instrRespData;
        opc_n       = resp_pc;
      end else if (!stall) begin
        out_valid_n = 1'b0;
        fault_n     = 1'b0;
      end

      buf_push    = keep && !bypass;
      buf_count_n = buf_count + CW'(buf_push) - CW'(buf_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= S_FETCH;
      pc                     <= RESET_VECTOR;
      outstanding            <= '0;
      drop_count             <= '0;
      buf_count              <= '0;
      buf_head               <= '0;
      buf_tail               <= '0;
      pcq_head               <= '0;
      pcq_tail               <= '0;
      outValid               <= 1'b0;
      outFetchFault          <= 1'b0;
      outInstruction         <= '0;
      outProgramCounter      <= '0;
      outProgramCounterPlus4 <= '0;
    end else begin
      state                  <= state_n;
      pc                     <= pc_n;
      outstanding            <= outstanding_n;
      drop_count             <= drop_n;
      buf_count              <= buf_count_n;
      outValid               <= out_valid_n;
      outFetchFault          <= fault_n;
      outInstruction         <= instr_n;
      outProgramCounter      <= opc_n;
      outProgramCounterPlus4 <= opc_n + 32'd4;

      if (accept) begin
        pcq_tail <= pcq_tail + 1'b1;
      end
      // Every response, kept or dropped, retires its PC tag.
      if (instrRespValid) begin
        pcq_head <= pcq_head + 1'b1;
      end

      if (redirectValid) begin
        buf_head <= '0;
        buf_tail <= '0;
      end else begin
        if (buf_push) begin
          buf_tail <= buf_tail + 1'b1;
        end
        if (buf_pop) begin
          buf_head <= buf_head + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      pcq[pcq_tail] <= pc;
    end
    if (buf_push && !redirectValid) begin
      buf_instr[buf_tail] <= instrRespData;
      buf_pc[buf_tail]    <= resp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(buf_push && !buf_pop && (buf_count == CW'(DEPTH))));

  a_resp_expected: assert property (@(posedge clock) disable iff (reset)
    !(instrRespValid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: program-order reference stream per redirect,
// memory model with random latency, directed corner scenarios.
module tb_fetch;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic        instrReqValid;
  logic        instrReqReady = 1'b0;
  logic [31:0] instrReqAddress;
  logic        instrRespValid = 1'b0;
  logic [31:0] instrRespData = '0;
  logic        outValid;
  logic [31:0] outInstruction;
  logic [31:0] outProgramCounter;
  logic [31:0] outProgramCounterPlus4;
  logic        outFetchFault;

  fetch #(.RESET_VECTOR(RV), .DEPTH(2)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .redirectValid(redirectValid),
    .redirectTarget(redirectTarget),
    .instrReqValid(instrReqValid),
    .instrReqReady(instrReqReady),
    .instrReqAddress(instrReqAddress),
    .instrRespValid(instrRespValid),
    .instrRespData(instrRespData),
    .outValid(outValid),
    .outInstruction(outInstruction),
    .outProgramCounter(outProgramCounter),
    .outProgramCounterPlus4(outProgramCounterPlus4),
    .outFetchFault(outFetchFault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } pay_t;

  pay_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] next_pc = RV;
  logic [31:0] pend_tg = '0;
  bit          halted = 1'b0;
  bit          pend_rd = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          delivered = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory: accepts at the coming edge, answers in order later.
  always @(negedge clock) begin
    if (!reset && instrReqValid && instrReqReady)
      mem_q.push_back(instrReqAddress);
  end

  // Monitor: a visible payload leaves when decode takes it or it is killed.
  always @(negedge clock) begin
    pay_t e;
    if (!reset) begin
      if (halted)
        chk("halt_noreq", 32'(instrReqValid), 32'd0);
      if (outValid && (!stall || flush || redirectValid)) begin
        delivered++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_payload: got pc %h want none",
                   outProgramCounter);
        end else begin
          e = exp_q.pop_front();
          chk("payload_pc", outProgramCounter, e.pc);
          chk("payload_pc4", outProgramCounterPlus4, e.pc + 32'd4);
          chk("payload_instr", outInstruction, e.instr);
          chk("payload_fault", 32'(outFetchFault), 32'(e.fault));
        end
      end
    end
  end

  task automatic step(input bit st, input bit fl, input bit rd,
                      input logic [31:0] tg, input bit rdy, input bit rsp);
    @(posedge clock);
    if (pend_rd) begin
      exp_q.delete();
      if (pend_tg[1:0] != 2'b00) begin
        exp_q.push_back('{pc: pend_tg, instr: 32'h0000_0013, fault: 1'b1});
        halted = 1'b1;
      end else begin
        next_pc = pend_tg;
        halted  = 1'b0;
      end
      pend_rd = 1'b0;
    end
    if (!halted) begin
      while (exp_q.size() < 8) begin
        exp_q.push_back('{pc: next_pc, instr: word_at(next_pc), fault: 1'b0});
        next_pc = next_pc + 32'd4;
      end
    end
    #1;
    stall          = st;
    flush          = fl;
    redirectValid  = rd;
    redirectTarget = tg;
    instrReqReady  = rdy;
    if (rsp && mem_q.size() > 0) begin
      instrRespValid = 1'b1;
      instrRespData  = word_at(mem_q.pop_front());
    end else begin
      instrRespValid = 1'b0;
      instrRespData  = '0;
    end
    if (rd) begin
      pend_rd = 1'b1;
      pend_tg = tg;
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset          = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    redirectValid  = 1'b0;
    instrReqReady  = 1'b0;
    instrRespValid = 1'b0;
    @(posedge clock);
    #1;
    mem_q.delete();
    exp_q.delete();
    next_pc = RV;
    halted  = 1'b0;
    pend_rd = 1'b0;
    @(negedge clock);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_fault", 32'(outFetchFault), 32'd0);
    chk("rst_instr", outInstruction, 32'd0);
    chk("rst_pc", outProgramCounter, 32'd0);
    chk("rst_pc4", outProgramCounterPlus4, 32'd0);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    instrReqReady = 1'b1;
    @(negedge clock);
    chk("post_rst_req", 32'(instrReqValid), 32'd1);
    chk("post_rst_addr", instrReqAddress, RV);
  endtask

  task automatic run_until_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clock);
      if (outValid) ok = 1'b1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no payload within 12 cycles want one", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int d0;

    // Streaming: PCs 0,4,8,12 on consecutive cycles.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clock);
      chk("stream_valid", 32'(outValid), 32'd1);
      chk("stream_pc", outProgramCounter, 32'(4 * k));
      chk("stream_pc4", outProgramCounterPlus4, 32'(4 * k + 4));
    end
    d0 = delivered;
    for (int k = 0; k < 10; k++)
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clock);
    chk("stream_rate", 32'(delivered - d0), 32'd10);

    // Backpressure with payload at PC 8 held for three cycles.
    do_reset();
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clock);
    chk("bp_hold_valid", 32'(outValid), 32'd1);
    chk("bp_hold_pc", outProgramCounter, 32'h8);
    chk("bp_req_blocked", 32'(instrReqValid), 32'd0);
    for (int k = 0; k < 6; k++)
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Redirect with two requests in flight.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    run_until_valid("redir_timeout", ok);
    if (ok) chk("redir_pc", outProgramCounter, 32'h100);

    // Misaligned redirect, fault held under stall, then recovery.
    step(1'b0, 1'b0, 1'b1, 32'h102, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clock);
    chk("mis_valid", 32'(outValid), 32'd1);
    chk("mis_fault", 32'(outFetchFault), 32'd1);
    chk("mis_instr", outInstruction, 32'h0000_0013);
    chk("mis_pc", outProgramCounter, 32'h102);
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clock);
    chk("mis_no_req", 32'(instrReqValid), 32'd0);
    chk("mis_drained", 32'(outValid), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    run_until_valid("recover_timeout", ok);
    if (ok) chk("recover_pc", outProgramCounter, 32'h200);

    // PC wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    run_until_valid("wrap_timeout", ok);
    if (ok) begin
      chk("wrap_pc", outProgramCounter, 32'hFFFF_FFFC);
      chk("wrap_pc4", outProgramCounterPlus4, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clock);
      chk("wrap_next_valid", 32'(outValid), 32'd1);
      chk("wrap_next_pc", outProgramCounter, 32'h0);
    end

    // Redirect, flush, stall and response together.
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clock);
    chk("all_in_one_valid", 32'(outValid), 32'd0);
    run_until_valid("all_in_one_timeout", ok);
    if (ok) chk("all_in_one_pc", outProgramCounter, 32'h300);

    // Randomized traffic against the program-order stream model.
    for (int i = 0; i < 3000; i++) begin
      bit          st;
      bit          fl;
      bit          rd;
      bit          rdy;
      bit          rsp;
      logic [31:0] tg;
      st  = ($urandom_range(0, 9) < 3);
      fl  = ($urandom_range(0, 19) == 0);
      rd  = halted ? ($urandom_range(0, 3) == 0)
                   : ($urandom_range(0, 24) == 0);
      tg  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
      if ($urandom_range(0, 3) == 0) tg[1:0] = 2'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 9) < 7);
      rsp = ($urandom_range(0, 9) < 7);
      if (i == 1500) do_reset();
      step(st, fl, rd, tg, rdy, rsp);
    end

    // Drain from an aligned address and require forward progress.
    step(1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1);
    d0 = delivered;
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clock);
    chk("drain_progress", 32'(delivered - d0 >= 15), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
